// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes and
// the bit positions of the NZCV flags within the 4-bit flags vector.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condition_check.sv
// Combinational 16-way decode of the instruction condition field against the
// stored NZCV flags.
module condition_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic ge;

  assign flag_n = flags[FLAG_N];
  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];
  assign ge     = (flag_n == flag_v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond_t'(cond))
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = ~flag_z & flag_c;
      COND_LS: cond_ex = flag_z | ~flag_c;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~flag_z & ge;
      COND_LE: cond_ex = flag_z | ~ge;
      COND_AL: cond_ex = 1'b1;
      // NV is unsupported: the instruction becomes a no-op.
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/conditional_logic.sv
// Conditional-execution stage: holds the NZCV flags register in two separately
// enabled halves and gates the decoder's PC, register and memory writes.
module conditional_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags
);

  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       nz_we;
  logic       cv_we;

  condition_check u_condition_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  // cond_ex is computed from the stored flags, so a flag-setting instruction
  // is always judged by the previous instruction's result.
  assign nz_we = flag_w[1] & cond_ex;
  assign cv_we = flag_w[0] & cond_ex;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_nz <= 2'b00;
    end else if (nz_we) begin
      flags_nz <= alu_flags[FLAG_N:FLAG_Z];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_cv <= 2'b00;
    end else if (cv_we) begin
      flags_cv <= alu_flags[FLAG_C:FLAG_V];
    end
  end

  assign flags     = {flags_nz, flags_cv};
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

endmodule

// File: doc/conditional_logic.md
# conditional_logic

Conditional-execution stage of the single-cycle processor control unit. It sits directly downstream of the control unit decoder (main decoder plus ALU decoder). It holds the architectural NZCV flags register and evaluates the instruction condition field against the stored flags. It then gates the decoder's write and branch requests so that an instruction whose condition fails has no architectural effect.

## Interface
Parameters:
- none. Widths are fixed by the ISA: 4-bit condition field, 4 flags.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cond`  in  4  instruction condition field, Instr[31:28]
- `alu_flags`  in  4  ALU flag outputs of the current instruction, {N,Z,C,V}
- `flag_w`  in  2  from ALU decoder; [1] requests N,Z update, [0] requests C,V update
- `pcs`  in  1  from decoder; instruction writes PC (branch, or write to R15)
- `reg_w`  in  1  from main decoder; register file write request
- `mem_w`  in  1  from main decoder; data memory write request
- `no_write`  in  1  from ALU decoder; compare-class op (CMP/CMN/TST), suppresses reg write
- `pc_src`  out  1  gated PC select to the datapath
- `reg_write`  out  1  gated register file write enable
- `mem_write`  out  1  gated data memory write enable
- `cond_ex`  out  1  condition passed for the current instruction
- `flags`  out  4  registered {N,Z,C,V}, for debug and the bench

## Operation
- Flags register has two independently enabled halves:
  - `flags[3:2]` (N,Z) loads `alu_flags[3:2]` when `flag_w[1] & cond_ex`.
  - `flags[1:0]` (C,V) loads `alu_flags[1:0]` when `flag_w[0] & cond_ex`.
- Condition check is combinational on `cond` and the registered `flags`:
  - 0000 EQ: Z; 0001 NE: ~Z; 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N; 0110 VS: V; 0111 VC: ~V
  - 1000 HI: ~Z&C; 1001 LS: Z|~C
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111: 0 (unsupported; the instruction executes as a no-op)
- Gated outputs:
  - `pc_src = pcs & cond_ex`
  - `reg_write = reg_w & cond_ex & ~no_write`
  - `mem_write = mem_w & cond_ex`
- A failed condition blocks all four effects: PC write, register write, memory write and flag update.

## Timing
- Reset, asynchronous on the falling `rst`: `flags` = 4'b0000 immediately, independent of `clk`.
- While `rst` is low, `flags` holds 0 and the gated outputs follow the combinational rules with flags = 0. Example: `cond`=1110 gives `cond_ex`=1; `cond`=0000 gives `cond_ex`=0.
- Reset mid-operation discards any pending flag update.
- Latency:
  - Gated outputs and `cond_ex` are zero-latency combinational, valid in the same cycle as their inputs.
  - Flag updates become visible on `flags` and in `cond_ex` from the cycle after the flag-setting instruction.
- A flag-setting instruction is evaluated against the old flags; its own result never affects its own `cond_ex`.
- `flag_w`=2'b11 with `cond_ex`=1 updates both halves on the same edge.
- `flag_w`=2'b10 leaves C,V unchanged; `flag_w`=2'b01 leaves N,Z unchanged.
- `alu_flags` is ignored on any edge where the enabled half's write is not taken.

## Structure
- Shared package `cond_pkg`:
  - enum `cond_t` with the 16 codes (EQ…AL, NV).
  - Flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One sub-module, `condition_check`: purely combinational, (`cond`, `flags`) → `cond_ex`, covering the 16-way decode.
- The top level keeps the two flag-register halves and the output gating.

## Test plan
1. Reset: assert `rst`=0 mid-cycle after loading flags 1111 → `flags`=0000 without waiting for a clock edge; `cond`=1110 gives `cond_ex`=1, `cond`=0000 gives `cond_ex`=0.
2. Split update: `cond`=AL, `alu_flags`=1010, `flag_w`=10, then one edge → `flags`=1000. Next cycle `alu_flags`=0101, `flag_w`=01 → `flags`=1001.
3. Suppression: with `flags`=0000 (Z=0), `cond`=EQ, `pcs`=`reg_w`=`mem_w`=1, `flag_w`=11, `alu_flags`=1111 → `pc_src`=`reg_write`=`mem_write`=0, `cond_ex`=0, and `flags` stays 0000 after the edge.
4. CMP then BEQ: cycle 0 `cond`=AL, `flag_w`=11, `no_write`=1, `reg_w`=1, `alu_flags`=0110 → `reg_write`=0. Cycle 1 `cond`=EQ, `pcs`=1 → `cond_ex`=1, `pc_src`=1.
5. Sweep all 16 `cond` values against all 16 flag values, loaded via AL with `flag_w`=11 → `cond_ex` matches the Operation list in all 256 cases, and 1111 always gives 0.
